// File: rtl/ov7670_reg_sequencer.sv
// ---------------------------------------------------------------------------
// ov7670_reg_sequencer
//
// Walks a fixed OV7670 register table and hands each {register, value} pair
// to an SCCB sender one write at a time. Entry 16'hF0F0 inserts a pause of
// DELAY_CYCLES clocks. Entry 16'hFFFF ends the sequence.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | one cycle: decode table[index] (write / delay / terminator)
// ST_SEND  | send=1, rega/value held until the sender pulses taken
// ST_DELAY | counting DELAY_CYCLES clocks before the next entry
// ST_DONE  | terminator reached, config_done=1, idle until resend/reset
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   resend       restart the table from entry 0
//   taken        one-cycle accept pulse from the SCCB sender
//   send         write request; rega/value are valid while it is high
//   id           constant SCCB device write address (DEVICE_ID)
//   rega, value  register address and data of the current entry
//   config_done  high in ST_DONE
//   busy         high in every state except ST_DONE
// ---------------------------------------------------------------------------
module ov7670_reg_sequencer #(
  parameter logic [7:0]  DEVICE_ID    = 8'h42,
  parameter int unsigned DELAY_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       resend,
  input  logic       taken,
  output logic       send,
  output logic [7:0] id,
  output logic [7:0] rega,
  output logic [7:0] value,
  output logic       config_done,
  output logic       busy
);

  localparam logic [15:0] LP_TERMINATOR = 16'hFFFF;
  localparam logic [15:0] LP_DELAY_MARK = 16'hF0F0;
  localparam logic [31:0] LP_CNT_LAST   = 32'(DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_index;
  logic [7:0]  w_index_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [7:0]  r_rega;
  logic [7:0]  w_rega_nxt;
  logic [7:0]  r_value;
  logic [7:0]  w_value_nxt;
  logic [15:0] w_entry;

  // Register table; everything past the terminator also reads as terminator.
  always_comb begin
    w_entry = LP_TERMINATOR;
    case (r_index)
      8'd0:    w_entry = 16'h1280;
      8'd1:    w_entry = LP_DELAY_MARK;
      8'd2:    w_entry = 16'h1204;
      8'd3:    w_entry = 16'h1180;
      8'd4:    w_entry = 16'h0C00;
      8'd5:    w_entry = 16'h3E00;
      8'd6:    w_entry = 16'h0400;
      8'd7:    w_entry = 16'h40D0;
      8'd8:    w_entry = 16'h3A04;
      default: w_entry = LP_TERMINATOR;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_cnt_nxt   = r_cnt;
    w_rega_nxt  = r_rega;
    w_value_nxt = r_value;

    if (resend) begin
      w_state_nxt = ST_FETCH;
      w_index_nxt = 8'd0;
      w_cnt_nxt   = 32'd0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_entry == LP_TERMINATOR) begin
            w_state_nxt = ST_DONE;
          end else if (w_entry == LP_DELAY_MARK) begin
            w_cnt_nxt   = 32'd0;
            w_state_nxt = ST_DELAY;
          end else begin
            w_rega_nxt  = w_entry[15:8];
            w_value_nxt = w_entry[7:0];
            w_state_nxt = ST_SEND;
          end
        end
        ST_SEND: begin
          if (taken) begin
            // Index 255 is the last slot; finishing it must not wrap to 0.
            if (r_index == 8'hFF) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_index_nxt = r_index + 8'd1;
              w_state_nxt = ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (r_cnt == LP_CNT_LAST) begin
            if (r_index == 8'hFF) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_index_nxt = r_index + 8'd1;
              w_state_nxt = ST_FETCH;
            end
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_index <= 8'd0;
      r_cnt   <= 32'd0;
      r_rega  <= 8'h00;
      r_value <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rega  <= w_rega_nxt;
      r_value <= w_value_nxt;
    end
  end

  assign send        = (r_state == ST_SEND);
  assign config_done = (r_state == ST_DONE);
  assign busy        = (r_state != ST_DONE);
  assign id          = DEVICE_ID;
  assign rega        = r_rega;
  assign value       = r_value;

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
module tb_ov7670_reg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       resend;
  logic       taken;
  logic       send;
  logic [7:0] id;
  logic [7:0] rega;
  logic [7:0] value;
  logic       config_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  localparam logic [15:0] EXP_WRITES [8] = '{
    16'h1280, 16'h1204, 16'h1180, 16'h0C00,
    16'h3E00, 16'h0400, 16'h40D0, 16'h3A04
  };

  ov7670_reg_sequencer #(
    .DEVICE_ID   (8'h42),
    .DELAY_CYCLES(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .resend     (resend),
    .taken      (taken),
    .send       (send),
    .id         (id),
    .rega       (rega),
    .value      (value),
    .config_done(config_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_table();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(EXP_WRITES[i]);
  endtask

  // Called at a negedge with send high: compare against scoreboard, verify the
  // pair stays stable for 3 cycles, then pulse taken and expect send to drop.
  task automatic accept_write(input string tag);
    logic [15:0] exp;
    logic [7:0]  r0, v0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected_write actual=%h_%h required=no_write", tag, rega, value);
    end else begin
      exp = exp_q.pop_front();
      if ({rega, value} !== exp) begin
        failures++;
        $display("FAIL %s_write actual=%h_%h required=%h_%h", tag, rega, value, exp[15:8], exp[7:0]);
      end
    end
    r0 = rega;
    v0 = value;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (send !== 1'b1 || rega !== r0 || value !== v0) begin
        failures++;
        $display("FAIL %s_hold actual=send%b_%h_%h required=send1_%h_%h", tag, send, rega, value, r0, v0);
      end
    end
    taken = 1'b1;
    @(negedge clk);
    taken = 1'b0;
    checks++;
    if (send !== 1'b0) begin
      failures++;
      $display("FAIL %s_send_drop actual=%b required=0", tag, send);
    end
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (send !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (send !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=send%b required=send1", tag, send);
    end else begin
      accept_write(tag);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (send !== 1'b0 || rega !== 8'h00 || value !== 8'h00 || config_done !== 1'b0 ||
        busy !== 1'b1 || id !== 8'h42) begin
      failures++;
      $display("FAIL %s actual=send%b_%h_%h_done%b_busy%b_id%h required=send0_00_00_done0_busy1_id42",
               tag, send, rega, value, config_done, busy, id);
    end
  endtask

  task automatic check_first_send(input string tag);
    checks++;
    if (send !== 1'b1 || rega !== 8'h12 || value !== 8'h80 || config_done !== 1'b0) begin
      failures++;
      $display("FAIL %s actual=send%b_%h_%h_done%b required=send1_12_80_done0",
               tag, send, rega, value, config_done);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    resend = 1'b0;
    taken  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    push_table();
    rst_n = 1'b1;
    @(negedge clk);
    check_first_send("first_send_latency");
  endtask

  // Entry 0 accepted, then FETCH + 10 DELAY + FETCH low cycles, then entry 2.
  // When pulse_taken is set, taken toggles inside the delay and must be ignored.
  task automatic test_delay(input string tag, input bit pulse_taken);
    int low;
    accept_write({tag, "_e0"});
    low = 1;
    while (send === 1'b0 && low < 50) begin
      taken = (pulse_taken && low >= 2 && low <= 9) ? low[0] : 1'b0;
      @(negedge clk);
      if (send === 1'b0) low++;
    end
    taken = 1'b0;
    checks++;
    if (low != 12) begin
      failures++;
      $display("FAIL %s_low_cycles actual=%0d required=12", tag, low);
    end
    wait_write({tag, "_e2"});
  endtask

  task automatic test_full_run(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      wait_write(tag);
      n++;
    end
    while (config_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (config_done !== 1'b1 || busy !== 1'b0 || send !== 1'b0) begin
      failures++;
      $display("FAIL %s_done actual=done%b_busy%b_send%b required=done1_busy0_send0",
               tag, config_done, busy, send);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes actual=%0d required=0", tag, exp_q.size());
    end
  endtask

  task automatic test_taken_in_done();
    for (int i = 0; i < 6; i++) begin
      taken = i[0];
      @(negedge clk);
      checks++;
      if (config_done !== 1'b1 || busy !== 1'b0 || send !== 1'b0) begin
        failures++;
        $display("FAIL taken_in_done actual=done%b_busy%b_send%b required=done1_busy0_send0",
                 config_done, busy, send);
      end
    end
    taken = 1'b0;
  endtask

  task automatic test_resend_at_entry5();
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
    push_table();
    @(negedge clk);
    check_first_send("resend_from_done");
    test_delay("delay_taken", 1'b1);
    wait_write("e3");
    wait_write("e4");
    begin
      int n = 0;
      while (send !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (send !== 1'b1 || {rega, value} !== 16'h3E00) begin
      failures++;
      $display("FAIL entry5_present actual=send%b_%h_%h required=send1_3e_00", send, rega, value);
    end
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
    checks++;
    if (send !== 1'b0 || config_done !== 1'b0) begin
      failures++;
      $display("FAIL resend_drop actual=send%b_done%b required=send0_done0", send, config_done);
    end
    push_table();
    @(negedge clk);
    check_first_send("resend_restart");
  endtask

  task automatic test_reset_in_done();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_in_done");
    rst_n = 1'b1;
    push_table();
    @(negedge clk);
    check_first_send("replay_after_reset");
    test_delay("replay", 1'b0);
    test_full_run("replay_run");
  endtask

  initial begin
    test_reset();
    test_delay("delay", 1'b0);
    test_full_run("full_run");
    test_taken_in_done();
    test_resend_at_entry5();
    test_full_run("after_resend");
    test_reset_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
